ir_command_latch: RTL and testbench

Bus-mapped command register that sits directly upstream of the IR transmitter state machine. It captures car commands written by the microprocessor, holds them in a pending slot, and hands them to the transmitter only at packet boundaries, so a command never changes mid-packet. An optional packet-count watchdog forces the command to stop (all zero) if software stops refreshing it. A one-cycle-latency status readback is provided on the bus.

---
 rtl/ir_command_latch.sv | 111 +++++++++++
 tb/tb_ir_command_latch.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/ir_command_latch.sv
// Bus-mapped IR command register: captures writes into a pending slot and applies them only at packet starts.
// Optional packet-count watchdog forcing a stop command is enabled with `define IR_CMD_WATCHDOG_EN.
module ir_command_latch #(
  parameter logic [7:0] IO_ADDRESS       = 8'h90,
  parameter logic [7:0] STATUS_ADDRESS   = 8'h91,
  parameter int         WATCHDOG_PACKETS = 20
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       BUS_WE,
  input  logic [7:0] BUS_ADDR,
  input  logic [7:0] BUS_DATA_IN,
  output logic [7:0] BUS_DATA_OUT,
  output logic       BUS_DATA_OUT_EN,
  input  logic       PACKET_START,
  input  logic       PACKET_DONE,
  output logic [3:0] COMMAND_OUT,
  output logic       PENDING,
  output logic       WATCHDOG_TRIPPED
);

  logic [3:0] pending_cmd;
  logic       write_hit;
  logic       read_cmd;
  logic       read_status;
  logic       apply;
  logic       trip;

  always_comb begin
    write_hit   = BUS_WE && (BUS_ADDR == IO_ADDRESS);
    read_cmd    = !BUS_WE && (BUS_ADDR == IO_ADDRESS);
    read_status = !BUS_WE && (BUS_ADDR == STATUS_ADDRESS);
    apply       = PACKET_START && PENDING;
  end

`ifdef IR_CMD_WATCHDOG_EN
  localparam int CNT_W = $clog2(WATCHDOG_PACKETS + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(WATCHDOG_PACKETS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WATCHDOG_PACKETS - 1);

  logic [CNT_W-1:0] wd_cnt;

  // Once saturated the counter cannot reach CNT_LAST again, so a trip fires only once per write.
  always_comb begin
    trip = PACKET_DONE && !write_hit && (wd_cnt == CNT_LAST);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      wd_cnt           <= '0;
      WATCHDOG_TRIPPED <= 1'b0;
    end else if (write_hit) begin
      wd_cnt           <= '0;
      WATCHDOG_TRIPPED <= 1'b0;
    end else if (PACKET_DONE && (wd_cnt != CNT_MAX)) begin
      wd_cnt <= wd_cnt + 1'b1;
      if (trip) begin
        WATCHDOG_TRIPPED <= 1'b1;
      end
    end
  end
`else
  logic unused_watchdog;

  always_comb begin
    trip            = 1'b0;
    unused_watchdog = PACKET_DONE;
  end

  assign WATCHDOG_TRIPPED = 1'b0;
`endif

  // Write beats a trip in the same cycle; the apply always consumes the pre-edge pending_cmd.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      pending_cmd <= 4'h0;
      PENDING     <= 1'b0;
    end else if (write_hit) begin
      pending_cmd <= BUS_DATA_IN[3:0];
      PENDING     <= 1'b1;
    end else if (trip) begin
      pending_cmd <= 4'h0;
      PENDING     <= 1'b1;
    end else if (apply) begin
      PENDING <= 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      COMMAND_OUT <= 4'h0;
    end else if (apply) begin
      COMMAND_OUT <= pending_cmd;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      BUS_DATA_OUT    <= 8'h00;
      BUS_DATA_OUT_EN <= 1'b0;
    end else begin
      BUS_DATA_OUT_EN <= read_cmd || read_status;
      if (read_cmd) begin
        BUS_DATA_OUT <= {4'h0, COMMAND_OUT};
      end else if (read_status) begin
        BUS_DATA_OUT <= {COMMAND_OUT, 2'b00, WATCHDOG_TRIPPED, PENDING};
      end
    end
  end

endmodule

// File: tb/tb_ir_command_latch.sv
// Testbench for ir_command_latch: directed table, corner-case sequences and random traffic vs. a reference model.
module tb_ir_command_latch;

  localparam int WD = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       we = 1'b0;
  logic [7:0] addr = 8'h00;
  logic [7:0] din = 8'h00;
  logic       st = 1'b0;
  logic       dn = 1'b0;
  logic [7:0] dout;
  logic       dout_en;
  logic [3:0] cmd_out;
  logic       pend;
  logic       tripped;

  int total = 0;
  int bad = 0;

  // reference model state
  logic [3:0] m_cmd, m_out;
  logic       m_pend, m_trip, m_en;
  logic [7:0] m_rd;
  int         m_cnt;

  ir_command_latch #(
    .IO_ADDRESS(8'h90),
    .STATUS_ADDRESS(8'h91),
    .WATCHDOG_PACKETS(WD)
  ) dut (
    .CLK(clk),
    .RESET(rst),
    .BUS_WE(we),
    .BUS_ADDR(addr),
    .BUS_DATA_IN(din),
    .BUS_DATA_OUT(dout),
    .BUS_DATA_OUT_EN(dout_en),
    .PACKET_START(st),
    .PACKET_DONE(dn),
    .COMMAND_OUT(cmd_out),
    .PENDING(pend),
    .WATCHDOG_TRIPPED(tripped)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural rules of one clock edge, applied in the order the events resolve.
  task automatic model_step();
    logic [7:0] rd_val;
    if (rst) begin
      m_cmd = 0; m_out = 0; m_pend = 0; m_trip = 0; m_en = 0; m_rd = 0; m_cnt = 0;
      return;
    end
    m_en = 0;
    if (!we && addr == 8'h90) begin
      m_rd = {4'h0, m_out}; m_en = 1;
    end else if (!we && addr == 8'h91) begin
      rd_val = {m_out, 4'h0};
      rd_val = rd_val + (m_trip ? 8'd2 : 8'd0) + (m_pend ? 8'd1 : 8'd0);
      m_rd = rd_val; m_en = 1;
    end
    if (st && m_pend) begin
      m_out = m_cmd; m_pend = 0;
    end
`ifdef IR_CMD_WATCHDOG_EN
    if (dn && m_cnt < WD) begin
      m_cnt = m_cnt + 1;
      if (m_cnt == WD) begin
        m_trip = 1; m_cmd = 0; m_pend = 1;
      end
    end
`endif
    if (we && addr == 8'h90) begin
      m_cmd = din[3:0]; m_pend = 1; m_cnt = 0; m_trip = 0;
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".cmd"}, {4'h0, cmd_out}, {4'h0, m_out});
    chk({tag, ".pend"}, {7'h0, pend}, {7'h0, m_pend});
    chk({tag, ".trip"}, {7'h0, tripped}, {7'h0, m_trip});
    chk({tag, ".en"}, {7'h0, dout_en}, {7'h0, m_en});
    chk({tag, ".rd"}, dout, m_rd);
  endtask

  // Drive one cycle of inputs, step the model on the edge, compare 1 time unit later.
  task automatic cycle(input logic r, input logic w, input logic [7:0] a, input logic [7:0] d,
                       input logic s, input logic p, input string tag);
    rst = r; we = w; addr = a; din = d; st = s; dn = p;
    @(posedge clk);
    model_step();
    #1;
    check_model(tag);
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) cycle(0, 0, 8'h00, 8'h00, 0, 0, tag);
  endtask

  typedef struct {
    logic       w;
    logic [7:0] a;
    logic [7:0] d;
    logic       s;
    logic [3:0] e_out;
    logic       e_pend;
    logic       e_en;
    logic [7:0] e_rd;
  } vec_t;

  vec_t tbl[11];

  initial begin
    tbl[0]  = '{0, 8'h00, 8'h00, 0, 4'h0, 0, 0, 8'h00};
    tbl[1]  = '{0, 8'h91, 8'h00, 0, 4'h0, 0, 1, 8'h00};
    tbl[2]  = '{0, 8'h00, 8'h00, 0, 4'h0, 0, 0, 8'h00};
    tbl[3]  = '{1, 8'h90, 8'hA5, 0, 4'h0, 1, 0, 8'h00};
    tbl[4]  = '{0, 8'h00, 8'h00, 1, 4'h5, 0, 0, 8'h00};
    tbl[5]  = '{0, 8'h90, 8'h00, 0, 4'h5, 0, 1, 8'h05};
    tbl[6]  = '{1, 8'h90, 8'h03, 0, 4'h5, 1, 0, 8'h05};
    tbl[7]  = '{1, 8'h90, 8'h09, 0, 4'h5, 1, 0, 8'h05};
    tbl[8]  = '{0, 8'h00, 8'h00, 1, 4'h9, 0, 0, 8'h05};
    tbl[9]  = '{1, 8'h90, 8'h0C, 1, 4'h9, 1, 0, 8'h05};
    tbl[10] = '{0, 8'h00, 8'h00, 1, 4'hC, 0, 0, 8'h05};

    // reset
    cycle(1, 0, 8'h00, 8'h00, 0, 0, "reset");
    cycle(1, 0, 8'h00, 8'h00, 0, 0, "reset");
    chk("reset.all", {dout_en, pend, tripped, 1'b0, cmd_out}, 8'h00);

    // directed table
    for (int i = 0; i < 11; i++) begin
      cycle(0, tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].s, 0, $sformatf("tbl%0d", i));
      chk($sformatf("tbl%0d.cmd", i), {4'h0, cmd_out}, {4'h0, tbl[i].e_out});
      chk($sformatf("tbl%0d.pend", i), {7'h0, pend}, {7'h0, tbl[i].e_pend});
      chk($sformatf("tbl%0d.en", i), {7'h0, dout_en}, {7'h0, tbl[i].e_en});
      chk($sformatf("tbl%0d.rd", i), dout, tbl[i].e_rd);
    end

    // write + start while a command is pending: old one applied, new one stays pending
    cycle(0, 1, 8'h90, 8'h02, 0, 0, "ws.w1");
    cycle(0, 1, 8'h90, 8'h0B, 1, 0, "ws.w2");
    chk("ws.cmd", {4'h0, cmd_out}, 8'h02);
    chk("ws.pend", {7'h0, pend}, 8'h01);
    cycle(0, 0, 8'h00, 8'h00, 1, 0, "ws.s");
    chk("ws.cmd2", {4'h0, cmd_out}, 8'h0B);
    // writes to the status address and elsewhere do nothing
    cycle(0, 1, 8'h91, 8'h07, 0, 0, "nw.status");
    cycle(0, 1, 8'h42, 8'h07, 1, 0, "nw.other");
    chk("nw.pend", {7'h0, pend}, 8'h00);

`ifdef IR_CMD_WATCHDOG_EN
    cycle(0, 1, 8'h90, 8'h06, 0, 0, "wd.w");
    cycle(0, 0, 8'h00, 8'h00, 1, 0, "wd.s");
    for (int i = 0; i < WD; i++) cycle(0, 0, 8'h00, 8'h00, 0, 1, "wd.d");
    chk("wd.trip", {7'h0, tripped}, 8'h01);
    cycle(0, 0, 8'h91, 8'h00, 0, 1, "wd.rd");
    chk("wd.status", dout, 8'h63);
    cycle(0, 0, 8'h00, 8'h00, 1, 0, "wd.stop");
    chk("wd.stopcmd", {4'h0, cmd_out}, 8'h00);
    cycle(0, 1, 8'h90, 8'h01, 0, 0, "wd.clr");
    chk("wd.cleared", {7'h0, tripped}, 8'h00);
    cycle(0, 0, 8'h00, 8'h00, 0, 1, "wc.d1");
    cycle(0, 0, 8'h00, 8'h00, 0, 1, "wc.d2");
    cycle(0, 1, 8'h90, 8'h04, 0, 1, "wc.wd3");
    chk("wc.notrip", {7'h0, tripped}, 8'h00);
    cycle(0, 0, 8'h00, 8'h00, 0, 1, "wc.d4");
    cycle(0, 0, 8'h00, 8'h00, 0, 1, "wc.d5");
    chk("wc.restart", {7'h0, tripped}, 8'h00);
    cycle(0, 0, 8'h00, 8'h00, 0, 1, "wc.d6");
    chk("wc.trip", {7'h0, tripped}, 8'h01);
    // start coincident with the tripping done: apply, then stop pending
    cycle(0, 1, 8'h90, 8'h0E, 0, 0, "sd.w");
    cycle(0, 0, 8'h00, 8'h00, 0, 1, "sd.d1");
    cycle(0, 0, 8'h00, 8'h00, 0, 1, "sd.d2");
    cycle(0, 0, 8'h00, 8'h00, 1, 1, "sd.sd");
    chk("sd.cmd", {4'h0, cmd_out}, 8'h0E);
    chk("sd.pend", {7'h0, pend}, 8'h01);
`else
    cycle(0, 1, 8'h90, 8'h06, 0, 0, "nd.w");
    cycle(0, 0, 8'h00, 8'h00, 1, 0, "nd.s");
    for (int i = 0; i < 100; i++) cycle(0, 0, 8'h00, 8'h00, 0, 1, "nd.d");
    chk("nd.cmd", {4'h0, cmd_out}, 8'h06);
    chk("nd.trip", {7'h0, tripped}, 8'h00);
`endif

    // reset mid-packet with a pending command
    cycle(0, 1, 8'h90, 8'h07, 0, 0, "rp.w");
    cycle(0, 0, 8'h00, 8'h00, 1, 0, "rp.s");
    cycle(0, 1, 8'h90, 8'h02, 0, 0, "rp.w2");
    chk("rp.pre", {3'h0, pend, cmd_out}, 8'h17);
    cycle(1, 0, 8'h91, 8'h00, 0, 0, "rp.rst");
    chk("rp.all", {dout_en, pend, tripped, 1'b0, cmd_out}, 8'h00);
    chk("rp.rd", dout, 8'h00);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      logic [7:0] a;
      case ($urandom_range(0, 3))
        0: a = 8'h91;
        1: a = $urandom_range(0, 255);
        default: a = 8'h90;
      endcase
      cycle($urandom_range(0, 99) == 0, $urandom_range(0, 2) == 0, a, 8'($urandom),
            $urandom_range(0, 4) == 0, $urandom_range(0, 2) == 0, "rnd");
    end
    idle(2, "end");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
